// File: rtl/wb_host_pkg.sv
// Shared Wishbone host definitions: bus widths, FSM state encoding and the
// slave-select field position shared with the address-decoding interconnect.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam int SLV_SEL_MSB = 31;
  localparam int SLV_SEL_LSB = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbh_state_e;

  function automatic logic [SLV_SEL_MSB-SLV_SEL_LSB:0] slave_sel(input logic [WB_ADR_W-1:0] adr);
    return adr[SLV_SEL_MSB:SLV_SEL_LSB];
  endfunction

endpackage

// File: rtl/wishbone_host_master_if.sv
// Host command/response stream plus Wishbone master port, bundled as one interface.
interface wishbone_host_master_if;
  import wb_host_pkg::*;

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [WB_ADR_W-1:0] cmd_adr_i;
  logic [WB_DAT_W-1:0] cmd_dat_i;
  logic [WB_SEL_W-1:0] cmd_sel_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [WB_DAT_W-1:0] rsp_dat_o;
  logic                rsp_err_o;

  logic                wbm_we_o;
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic [WB_DAT_W-1:0] wbm_dat_i;
  logic                wbm_ack_i;
  logic                wbm_int_i;
  logic                int_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wbm_dat_i, wbm_ack_i, wbm_int_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, int_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wbm_dat_i, wbm_ack_i, wbm_int_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, int_o
  );

endinterface

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: counts BUS cycles without ACK, flags the terminal count.
module wb_host_timeout #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt_q <= '0;
    else if (inc)     cnt_q <= cnt_q + 16'd1;
  end

  assign expired = (cnt_q == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/wishbone_host_master.sv
// Host command stream -> classic single Wishbone cycles, one outstanding at a time.
// Optional ACK watchdog enabled by defining WB_HOST_MASTER_TIMEOUT_EN.
module wishbone_host_master
  import wb_host_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_host_master_if.master bus
);

  wbh_state_e state_q;
  logic       timeout;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  // Counter sits at zero outside BUS, so it is already cleared on entry.
  wb_host_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != BUS),
    .inc     (state_q == BUS && !bus.wbm_ack_i),
    .expired (timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bus.cmd_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.wbm_we_o    <= 1'b0;
      bus.wbm_cyc_o   <= 1'b0;
      bus.wbm_stb_o   <= 1'b0;
      bus.wbm_sel_o   <= '0;
      bus.wbm_adr_o   <= '0;
      bus.wbm_dat_o   <= '0;
      bus.int_o       <= 1'b0;
    end else begin
      bus.int_o <= bus.wbm_int_i;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.wbm_we_o    <= bus.cmd_we_i;
            bus.wbm_adr_o   <= bus.cmd_adr_i;
            bus.wbm_dat_o   <= bus.cmd_dat_i;
            bus.wbm_sel_o   <= bus.cmd_sel_i;
            bus.wbm_cyc_o   <= 1'b1;
            bus.wbm_stb_o   <= 1'b1;
            bus.cmd_ready_o <= 1'b0;
            state_q         <= BUS;
          end else begin
            bus.cmd_ready_o <= 1'b1;
          end
        end
        BUS: begin
          // ACK beats the watchdog when both land in the same cycle.
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.rsp_dat_o   <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state_q         <= RESP;
          end else if (timeout) begin
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.rsp_dat_o   <= '0;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_valid_o <= 1'b1;
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_host_master.sv
// Randomized bench for wishbone_host_master against a transaction-level model.
// Honors WB_HOST_MASTER_TIMEOUT_EN (TIMEOUT_CYCLES=8 when enabled).
module tb_wishbone_host_master;

  localparam int TO = 8;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  wishbone_host_master_if bus ();

  wishbone_host_master #(.TIMEOUT_CYCLES(16'(TO))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  // Reference: a command whose ACK arrives on BUS cycle ack_wait+1 holds CYC that
  // long, unless the watchdog fires first after TO cycles.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_wait, input logic [31:0] rdata,
                        input int rsp_delay, input bit bp_cmd);
    bit          exp_err;
    int          exp_cyc, n, guard;
    logic [31:0] exp_dat;
    exp_err = TO_EN && (ack_wait + 1 > TO);
    exp_cyc = exp_err ? TO : ack_wait + 1;
    exp_dat = (exp_err || we) ? 32'h0 : rdata;

    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    guard = 0;
    while (bus.cmd_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_bound", 32'(guard), 32'd0);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dat_i   = $urandom;
    bus.cmd_adr_i   = $urandom;
    chk("cmd_ready_drop", 32'(bus.cmd_ready_o), 32'd0);

    n = 0;
    while (bus.wbm_cyc_o === 1'b1 && n < 200) begin
      n++;
      chk("bus_stb", 32'(bus.wbm_stb_o), 32'd1);
      chk("bus_we",  32'(bus.wbm_we_o),  32'(we));
      chk("bus_adr", bus.wbm_adr_o, adr);
      chk("bus_dat", bus.wbm_dat_o, dat);
      chk("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
      if (n == ack_wait + 1) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rdata;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;
      end
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;
    chk("cyc_len",   32'(n), 32'(exp_cyc));
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("rsp_dat",   bus.rsp_dat_o, exp_dat);
    chk("rsp_err",   32'(bus.rsp_err_o), 32'(exp_err));
    chk("end_stb",   32'(bus.wbm_stb_o), 32'd0);
    chk("end_we",    32'(bus.wbm_we_o), 32'd0);
    chk("end_adr",   bus.wbm_adr_o, adr);

    for (int i = 0; i < rsp_delay; i++) begin
      if (bp_cmd) begin
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'($urandom);
        bus.cmd_adr_i   = $urandom;
      end
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("hold_dat",   bus.rsp_dat_o, exp_dat);
      chk("hold_err",   32'(bus.rsp_err_o), 32'(exp_err));
      chk("hold_ready", 32'(bus.cmd_ready_o), 32'd0);
      chk("hold_cyc",   32'(bus.wbm_cyc_o), 32'd0);
    end
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("rsp_done",  32'(bus.rsp_valid_o), 32'd0);
    chk("ready_ret", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    int guard;
    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_dat_i   = '0;
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_int_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("rst_cyc",   32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_rspv",  32'(bus.rsp_valid_o), 32'd0);
    chk("rst_adr",   bus.wbm_adr_o, 32'd0);
    chk("rst_int",   32'(bus.int_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready_o), 32'd1);

    do_txn(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 4'hF, 3, $urandom, 0, 1'b0);
    do_txn(1'b0, 32'h0000_0004, $urandom, 4'hF, 0, 32'h1234_5678, 2, 1'b0);
    do_txn(1'b0, $urandom, $urandom, 4'h3, 1, $urandom, 5, 1'b1);
    do_txn(1'b1, $urandom, $urandom, 4'h1, 0, $urandom, 0, 1'b0);

    if (TO_EN) begin
      do_txn(1'b0, 32'h0200_0000, $urandom, 4'hF, 1000, $urandom, 1, 1'b0);
      do_txn(1'b1, 32'h0200_0004, $urandom, 4'hF, TO - 1, $urandom, 0, 1'b0);
      do_txn(1'b0, 32'h0200_0008, $urandom, 4'hF, TO - 1, 32'hCAFE_F00D, 0, 1'b0);
    end

    // interrupt passthrough
    chk("int_idle", 32'(bus.int_o), 32'd0);
    bus.wbm_int_i = 1'b1;
    @(negedge clk);
    bus.wbm_int_i = 1'b0;
    chk("int_rise", 32'(bus.int_o), 32'd1);
    @(negedge clk);
    chk("int_fall", 32'(bus.int_o), 32'd0);

    // reset while a cycle is in flight
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h0300_0000;
    guard = 0;
    while (bus.cmd_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("mid_cyc_up", 32'(bus.wbm_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc",   32'(bus.wbm_cyc_o), 32'd0);
    chk("mid_rst_stb",   32'(bus.wbm_stb_o), 32'd0);
    chk("mid_rst_rspv",  32'(bus.rsp_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", 32'(bus.cmd_ready_o), 32'd1);
    do_txn(1'b0, 32'h0000_0008, $urandom, 4'hF, 2, 32'h0BAD_F00D, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, TO_EN ? 12 : 5)), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
